// File: rtl/predict_pkg.sv
// Shared types for the branch-target table write sequencer.
package predict_pkg;

   localparam int IDX_W = 12;
   localparam int XLEN  = 32;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [XLEN-1:0]  target;
      logic             taken;
   } pred_upd_t;

   typedef enum logic {
      SWEEP = 1'b0,
      RUN   = 1'b1
   } ctrl_state_e;

endpackage

// File: rtl/predict_upd_fifo.sv
// Pending-update FIFO; a push whose idx hits a queued entry that is
// not leaving this cycle rewrites that entry instead of allocating.
module predict_upd_fifo
   import predict_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  logic      i_push,
   input  logic      i_pop,
   input  logic      i_clr,
   input  pred_upd_t i_data,
   output pred_upd_t o_head,
   output logic      o_full,
   output logic      o_empty
);

   localparam int AW = $clog2(DEPTH);

   pred_upd_t     r_mem [DEPTH];
   logic [AW-1:0] r_rd;
   logic [AW-1:0] r_wr;
   logic [AW:0]   r_cnt;

   logic          w_hit;
   logic [AW-1:0] w_hit_idx;
   logic          w_new;

   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         logic [AW-1:0] w_off;
         w_off = AW'(i) - r_rd;
         if (({1'b0, w_off} < r_cnt) &&
             (r_mem[i].idx == i_data.idx) &&
             !(i_pop && (AW'(i) == r_rd))) begin
            w_hit     = 1'b1;
            w_hit_idx = AW'(i);
         end
      end
   end

   assign w_new   = i_push && !w_hit;
   assign o_head  = r_mem[r_rd];
   assign o_full  = (r_cnt == (AW+1)'(DEPTH));
   assign o_empty = (r_cnt == '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_clr) begin
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push && w_hit) begin
            r_mem[w_hit_idx].target <= i_data.target;
            r_mem[w_hit_idx].taken  <= i_data.taken;
         end
         if (w_new) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= r_wr + AW'(1);
         end
         if (i_pop) r_rd <= r_rd + AW'(1);
         r_cnt <= r_cnt + {{AW{1'b0}}, w_new}
                        - {{AW{1'b0}}, i_pop};
      end
   end

endmodule

// File: rtl/predict_ctrl.sv
// Write-port sequencer for the branch-target table: invalidate sweep
// after reset/flush, then drains buffered Execute updates.
module predict_ctrl
   import predict_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             upd_valid_i,
   output logic             upd_ready_o,
   input  logic [IDX_W-1:0] upd_idx_i,
   input  logic [XLEN-1:0]  upd_target_i,
   input  logic             upd_taken_i,
   input  logic             flush_req_i,
   output logic             flush_busy_o,
   output logic             flush_done_o,
   output logic             pred_en_o,
   output logic             wr_en_o,
   output logic [IDX_W-1:0] wr_idx_o,
   output logic [XLEN-1:0]  wr_target_o,
   output logic             wr_valid_o,
   output logic [15:0]      drop_cnt_o
);

   localparam logic [IDX_W:0] CNT_ONE = {{IDX_W{1'b0}}, 1'b1};

   ctrl_state_e      r_state;
   logic [IDX_W:0]   r_cnt;
   logic             r_wr_en;
   logic [IDX_W-1:0] r_wr_idx;
   logic [XLEN-1:0]  r_wr_target;
   logic             r_wr_valid;
   logic             r_done;
   logic             r_pred_en;
   logic [15:0]      r_drop;

   logic      w_run;
   logic      w_full;
   logic      w_empty;
   logic      w_pop;
   logic      w_push;
   logic      w_clr;
   logic      w_drop;
   pred_upd_t w_upd;
   pred_upd_t w_head;

   assign w_run  = (r_state == RUN);
   assign w_upd  = {upd_idx_i, upd_target_i, upd_taken_i};
   assign w_pop  = w_run && !w_empty;
   assign w_clr  = w_run && flush_req_i;
   assign w_push = upd_valid_i && upd_ready_o && !flush_req_i;
   assign w_drop = upd_valid_i && !upd_ready_o;

   predict_upd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_clr   (w_clr),
      .i_data  (w_upd),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Counter carries one extra bit so the completion cycle follows the last write.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= SWEEP;
         r_cnt       <= '0;
         r_wr_en     <= 1'b0;
         r_wr_idx    <= '0;
         r_wr_target <= '0;
         r_wr_valid  <= 1'b0;
         r_done      <= 1'b0;
         r_pred_en   <= 1'b0;
         r_drop      <= '0;
      end else begin
         r_done  <= 1'b0;
         r_wr_en <= 1'b0;
         if (w_drop && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
         unique case (r_state)
            SWEEP: begin
               if (r_cnt[IDX_W]) begin
                  r_state   <= RUN;
                  r_done    <= 1'b1;
                  r_pred_en <= 1'b1;
               end else begin
                  r_wr_en     <= 1'b1;
                  r_wr_idx    <= r_cnt[IDX_W-1:0];
                  r_wr_target <= '0;
                  r_wr_valid  <= 1'b0;
                  r_cnt       <= r_cnt + CNT_ONE;
               end
            end
            RUN: begin
               if (w_pop) begin
                  r_wr_en     <= 1'b1;
                  r_wr_idx    <= w_head.idx;
                  r_wr_target <= w_head.target;
                  r_wr_valid  <= w_head.taken;
               end
               if (flush_req_i) begin
                  r_state   <= SWEEP;
                  r_cnt     <= '0;
                  r_pred_en <= 1'b0;
               end
            end
            default: r_state <= SWEEP;
         endcase
      end
   end

   assign upd_ready_o  = w_run && !w_full;
   assign flush_busy_o = (r_state == SWEEP);
   assign flush_done_o = r_done;
   assign pred_en_o    = r_pred_en;
   assign wr_en_o      = r_wr_en;
   assign wr_idx_o     = r_wr_idx;
   assign wr_target_o  = r_wr_target;
   assign wr_valid_o   = r_wr_valid;
   assign drop_cnt_o   = r_drop;

endmodule
